// File: rtl/ahb_arbiter.sv
// AHB-lite multi-master arbiter with round-robin grant, lock support and a
// hold limit; muxes the granted master's address phase and the data-phase
// owner's write data onto the shared bus segment.
module ahb_arbiter #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned MAX_HOLD       = 8,
    localparam int unsigned MW            = $clog2(NUM_MASTERS)
) (
    input  logic                              i_hclk,
    input  logic                              i_hreset,
    input  logic [NUM_MASTERS-1:0]            i_hbusreq,
    input  logic [NUM_MASTERS-1:0]            i_hlock,
    input  logic [2*NUM_MASTERS-1:0]          i_htrans_m,
    input  logic [ADDR_WIDTH*NUM_MASTERS-1:0] i_haddr_m,
    input  logic [NUM_MASTERS-1:0]            i_hwrite_m,
    input  logic [3*NUM_MASTERS-1:0]          i_hsize_m,
    input  logic [DATA_WIDTH*NUM_MASTERS-1:0] i_hwdata_m,
    input  logic                              i_hready,
    output logic [NUM_MASTERS-1:0]            o_hgrant,
    output logic [MW-1:0]                     o_hmaster,
    output logic [1:0]                        o_htrans,
    output logic [ADDR_WIDTH-1:0]             o_haddr,
    output logic                              o_hwrite,
    output logic [2:0]                        o_hsize,
    output logic                              o_hmastlock,
    output logic [DATA_WIDTH-1:0]             o_hwdata
);

    // Saturating counter only needs to reach MAX_HOLD.
    localparam int unsigned HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransBusy   = 2'b01;
    localparam logic [1:0] HtransNonseq = 2'b10;
    localparam logic [1:0] HtransSeq    = 2'b11;

    localparam logic [MW-1:0]          DefaultIdx   = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DefaultGrant = NUM_MASTERS'(1) << DEFAULT_MASTER;

    logic [MW-1:0]          addr_owner_q, addr_owner_d;
    logic [MW-1:0]          data_owner_q;
    logic [MW-1:0]          winner;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
    logic                   owner_req;
    logic                   owner_lock;
    logic                   others_req;
    logic                   owner_active;
    logic                   hold_expired;
    logic [1:0]             owner_trans;

    // Address-phase mux and per-owner status, selected by the address owner.
    always_comb begin
        o_htrans    = HtransIdle;
        o_haddr     = '0;
        o_hwrite    = 1'b0;
        o_hsize     = '0;
        o_hmastlock = 1'b0;
        owner_req   = 1'b0;
        others_req  = 1'b0;
        for (int k = 0; k < int'(NUM_MASTERS); k++) begin
            if (addr_owner_q == MW'(k)) begin
                o_htrans    = i_htrans_m[2*k +: 2];
                o_haddr     = i_haddr_m[k*ADDR_WIDTH +: ADDR_WIDTH];
                o_hwrite    = i_hwrite_m[k];
                o_hsize     = i_hsize_m[3*k +: 3];
                o_hmastlock = i_hlock[k];
                owner_req   = i_hbusreq[k];
            end else if (i_hbusreq[k]) begin
                others_req = 1'b1;
            end
        end
    end

    assign owner_trans  = o_htrans;
    assign owner_lock   = o_hmastlock;
    assign owner_active = (owner_trans == HtransNonseq) || (owner_trans == HtransSeq);
    // Count includes the transfer being accepted on this edge, so the owner
    // gets exactly MAX_HOLD transfers before yielding.
    assign hold_expired = (MAX_HOLD != 0) &&
                          ((32'(hold_cnt_q) + 32'(owner_active)) >= MAX_HOLD);

    // Write-data mux, selected by the data-phase owner.
    always_comb begin
        o_hwdata = '0;
        for (int k = 0; k < int'(NUM_MASTERS); k++) begin
            if (data_owner_q == MW'(k)) begin
                o_hwdata = i_hwdata_m[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Round-robin winner: nearest requester after the current owner; the
    // descending scan lets the closest one overwrite farther ones.
    always_comb begin
        winner = addr_owner_q;
        for (int d = int'(NUM_MASTERS) - 1; d >= 1; d--) begin
            for (int j = 0; j < int'(NUM_MASTERS); j++) begin
                if (i_hbusreq[j] &&
                    ((int'(addr_owner_q) + d) % int'(NUM_MASTERS) == j)) begin
                    winner = MW'(j);
                end
            end
        end
    end

    // Next owner, one-hot grant and hold counter.
    always_comb begin
        addr_owner_d = addr_owner_q;
        hold_cnt_d   = hold_cnt_q;
        if (i_hready && !owner_lock) begin
            if (i_hbusreq == '0) begin
                addr_owner_d = DefaultIdx;
            end else if (others_req &&
                         (!owner_req || (owner_trans == HtransIdle) ||
                          (hold_expired && (owner_trans != HtransBusy)))) begin
                addr_owner_d = winner;
            end
        end
        if (i_hready) begin
            if (addr_owner_d != addr_owner_q) begin
                hold_cnt_d = '0;
            end else if (owner_active && (32'(hold_cnt_q) < MAX_HOLD)) begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end
        end
        grant_d = '0;
        for (int k = 0; k < int'(NUM_MASTERS); k++) begin
            grant_d[k] = (addr_owner_d == MW'(k));
        end
    end

    // Ownership state; data owner trails the address owner by one ready edge.
    always_ff @(posedge i_hclk or negedge i_hreset) begin
        if (!i_hreset) begin
            addr_owner_q <= DefaultIdx;
            data_owner_q <= DefaultIdx;
            grant_q      <= DefaultGrant;
            hold_cnt_q   <= '0;
        end else begin
            addr_owner_q <= addr_owner_d;
            grant_q      <= grant_d;
            hold_cnt_q   <= hold_cnt_d;
            if (i_hready) begin
                data_owner_q <= addr_owner_q;
            end
        end
    end

    assign o_hgrant  = grant_q;
    assign o_hmaster = addr_owner_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: a vector table for single-cycle behaviour
// plus hand-written sequences for lock, wait states, hold limit and reset.
module tb_ahb_arbiter;

    localparam logic [1:0] TI = 2'b00;
    localparam logic [1:0] TB = 2'b01;
    localparam logic [1:0] TN = 2'b10;
    localparam logic [1:0] TS = 2'b11;

    localparam logic [31:0] AD0 = 32'h0000_0100;
    localparam logic [31:0] AD1 = 32'h0000_0010;
    localparam logic [31:0] WD0 = 32'hA0A0_0000;
    localparam logic [31:0] WD1 = 32'hB1B1_1111;

    logic        clk;
    logic        rst_n;
    logic [1:0]  busreq;
    logic [1:0]  hlock;
    logic [1:0]  tr0, tr1;
    logic [3:0]  htrans_m;
    logic [63:0] haddr_m;
    logic [1:0]  hwrite_m;
    logic [5:0]  hsize_m;
    logic [63:0] hwdata_m;
    logic        hready;

    logic [1:0]  grant, grant1;
    logic        hmaster, hmaster1;
    logic [1:0]  htrans, htrans1;
    logic [31:0] haddr, haddr1;
    logic        hwrite, hwrite1;
    logic [2:0]  hsize, hsize1;
    logic        mlock, mlock1;
    logic [31:0] hwdata, hwdata1;

    int total = 0;
    int bad   = 0;

    assign htrans_m = {tr1, tr0};
    assign haddr_m  = {AD1, AD0};
    assign hwdata_m = {WD1, WD0};
    assign hwrite_m = 2'b10;          // M0 reads, M1 writes
    assign hsize_m  = {3'd2, 3'd1};   // M0 halfword, M1 word

    ahb_arbiter #(.NUM_MASTERS(2), .MAX_HOLD(2)) u_dut (
        .i_hclk(clk), .i_hreset(rst_n), .i_hbusreq(busreq), .i_hlock(hlock),
        .i_htrans_m(htrans_m), .i_haddr_m(haddr_m), .i_hwrite_m(hwrite_m),
        .i_hsize_m(hsize_m), .i_hwdata_m(hwdata_m), .i_hready(hready),
        .o_hgrant(grant), .o_hmaster(hmaster), .o_htrans(htrans), .o_haddr(haddr),
        .o_hwrite(hwrite), .o_hsize(hsize), .o_hmastlock(mlock), .o_hwdata(hwdata)
    );

    ahb_arbiter #(.NUM_MASTERS(2), .MAX_HOLD(1)) u_dut_h1 (
        .i_hclk(clk), .i_hreset(rst_n), .i_hbusreq(busreq), .i_hlock(hlock),
        .i_htrans_m(htrans_m), .i_haddr_m(haddr_m), .i_hwrite_m(hwrite_m),
        .i_hsize_m(hsize_m), .i_hwdata_m(hwdata_m), .i_hready(hready),
        .o_hgrant(grant1), .o_hmaster(hmaster1), .o_htrans(htrans1), .o_haddr(haddr1),
        .o_hwrite(hwrite1), .o_hsize(hsize1), .o_hmastlock(mlock1), .o_hwdata(hwdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  lock;
        logic [1:0]  t0;
        logic [1:0]  t1;
        logic        rdy;
        logic [1:0]  grant;
        logic [1:0]  htrans;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        mlock;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic apply(input logic [1:0] req, input logic [1:0] lk, input logic [1:0] t0,
                         input logic [1:0] t1, input logic rdy);
        busreq = req;
        hlock  = lk;
        tr0    = t0;
        tr1    = t1;
        hready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges; called one time unit after an edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        apply(2'b00, 2'b00, TI, TI, 1'b1);
        #12;
        rst_n = 1'b1;
        #1;
        check("reset grant", grant, 2'b01);
        check("reset hmaster", hmaster, 0);
        check("reset htrans", htrans, TI);
        check("reset hwdata", hwdata, WD0);
        check("reset hold_cnt", u_dut.hold_cnt_q, 0);
        check("reset mastlock", mlock, 1'b0);
        tick();

        //          req    lock   t0 t1 rdy grant  htrans addr wdata mlock
        vecs[0]  = '{2'b00, 2'b00, TI, TI, 1, 2'b01, TI, AD0, WD0, 0};
        vecs[1]  = '{2'b10, 2'b00, TI, TN, 1, 2'b01, TI, AD0, WD0, 0};
        vecs[2]  = '{2'b10, 2'b00, TI, TN, 1, 2'b10, TN, AD1, WD0, 0};
        vecs[3]  = '{2'b10, 2'b00, TI, TN, 1, 2'b10, TN, AD1, WD1, 0};
        vecs[4]  = '{2'b11, 2'b00, TN, TN, 1, 2'b10, TN, AD1, WD1, 0};
        vecs[5]  = '{2'b11, 2'b00, TN, TN, 0, 2'b01, TN, AD0, WD1, 0};
        vecs[6]  = '{2'b11, 2'b00, TN, TN, 0, 2'b01, TN, AD0, WD1, 0};
        vecs[7]  = '{2'b11, 2'b00, TN, TN, 1, 2'b01, TN, AD0, WD1, 0};
        vecs[8]  = '{2'b11, 2'b00, TN, TN, 1, 2'b01, TN, AD0, WD0, 0};
        vecs[9]  = '{2'b11, 2'b00, TN, TN, 1, 2'b10, TN, AD1, WD0, 0};
        vecs[10] = '{2'b00, 2'b00, TI, TI, 1, 2'b10, TI, AD1, WD1, 0};
        vecs[11] = '{2'b00, 2'b00, TI, TI, 1, 2'b01, TI, AD0, WD1, 0};
        vecs[12] = '{2'b00, 2'b00, TI, TI, 1, 2'b01, TI, AD0, WD0, 0};
        vecs[13] = '{2'b10, 2'b00, TI, TN, 0, 2'b01, TI, AD0, WD0, 0};
        vecs[14] = '{2'b00, 2'b00, TI, TI, 0, 2'b01, TI, AD0, WD0, 0};
        vecs[15] = '{2'b00, 2'b00, TI, TI, 1, 2'b01, TI, AD0, WD0, 0};
        vecs[16] = '{2'b00, 2'b00, TI, TI, 1, 2'b01, TI, AD0, WD0, 0};
        vecs[17] = '{2'b11, 2'b10, TI, TN, 1, 2'b01, TI, AD0, WD0, 0};
        vecs[18] = '{2'b11, 2'b10, TN, TN, 1, 2'b10, TN, AD1, WD0, 1};

        for (int i = 0; i < 19; i++) begin
            apply(vecs[i].req, vecs[i].lock, vecs[i].t0, vecs[i].t1, vecs[i].rdy);
            #1;
            check($sformatf("v%0d grant", i), grant, vecs[i].grant);
            check($sformatf("v%0d hmaster", i), hmaster, vecs[i].grant[1]);
            check($sformatf("v%0d htrans", i), htrans, vecs[i].htrans);
            check($sformatf("v%0d haddr", i), haddr, vecs[i].addr);
            check($sformatf("v%0d hwrite", i), hwrite, vecs[i].grant[1]);
            check($sformatf("v%0d hsize", i), hsize, vecs[i].grant[1] ? 3'd2 : 3'd1);
            check($sformatf("v%0d hwdata", i), hwdata, vecs[i].wdata);
            check($sformatf("v%0d mastlock", i), mlock, vecs[i].mlock);
            tick();
        end

        // Locked 8-beat burst from M0 while M1 requests; no early termination.
        do_reset();
        for (int b = 0; b < 8; b++) begin
            apply(2'b11, 2'b01, (b == 0) ? TN : TS, TN, 1'b1);
            #1;
            check($sformatf("lock b%0d grant", b), grant, 2'b01);
            check($sformatf("lock b%0d mastlock", b), mlock, 1'b1);
            tick();
        end
        apply(2'b10, 2'b00, TI, TN, 1'b1);
        #1;
        check("lock release grant", grant, 2'b01);
        check("lock release mastlock", mlock, 1'b0);
        tick();
        #1;
        check("lock handover grant", grant, 2'b10);
        check("lock handover haddr", haddr, AD1);
        tick();

        // Three wait states during M0's transfer while M1 requests.
        do_reset();
        apply(2'b01, 2'b00, TN, TI, 1'b1);
        #1;
        check("wait first grant", grant, 2'b01);
        tick();
        for (int w = 0; w < 3; w++) begin
            apply(2'b10, 2'b00, TI, TN, 1'b0);
            #1;
            check($sformatf("wait w%0d grant", w), grant, 2'b01);
            check($sformatf("wait w%0d hwdata", w), hwdata, WD0);
            tick();
        end
        apply(2'b10, 2'b00, TI, TN, 1'b1);
        #1;
        check("wait ready grant", grant, 2'b01);
        check("wait ready hwdata", hwdata, WD0);
        tick();
        #1;
        check("wait switched grant", grant, 2'b10);
        check("wait handover hwdata", hwdata, WD0);
        tick();
        #1;
        check("wait new hwdata", hwdata, WD1);
        tick();

        // MAX_HOLD=1 instance: continuous requests alternate every transfer.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            apply(2'b11, 2'b00, TN, TN, 1'b1);
            #1;
            check($sformatf("alt c%0d grant", c), grant1, (c % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("alt c%0d htrans", c), htrans1, TN);
            check($sformatf("alt c%0d haddr", c), haddr1, (c % 2 == 0) ? AD0 : AD1);
            check($sformatf("alt c%0d hwdata", c), hwdata1,
                  (c == 0 || c % 2 == 1) ? WD0 : WD1);
            tick();
        end

        // Asynchronous reset in the middle of an M1 burst.
        do_reset();
        apply(2'b10, 2'b00, TI, TN, 1'b1);
        #1;
        check("rst pre grant", grant, 2'b01);
        tick();
        apply(2'b10, 2'b00, TI, TN, 1'b1);
        #1;
        check("rst m1 grant", grant, 2'b10);
        tick();
        apply(2'b10, 2'b00, TI, TS, 1'b1);
        #1;
        check("rst burst grant", grant, 2'b10);
        check("rst burst hold_cnt", u_dut.hold_cnt_q, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst async grant", grant, 2'b01);
        check("rst async hmaster", hmaster, 0);
        check("rst async hold_cnt", u_dut.hold_cnt_q, 0);
        check("rst async hwdata", hwdata, WD0);
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
